date_bcd_counter: RTL and testbench

- Calendar date stage directly downstream of the 24-hour time-of-day chain. Consumes a one-cycle day-rollover pulse, generated when the hour counter wraps 23->00, and advances a BCD day/month/year date.
- Full Gregorian leap-year rules and per-month lengths apply.
- Outputs are BCD digits that feed the seven-segment and LED display decoders directly.
- Includes a synchronous, validated date-load port for the setting logic.

---
 rtl/date_bcd_counter.sv | 149 ++++++++++++++
 tb/tb_date_bcd_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/date_bcd_counter.sv
// BCD calendar date counter: advances day/month/year on a day rollover pulse and
// accepts validated date loads from the setting logic.
module date_bcd_counter #(
   parameter logic [15:0] RESET_YEAR  = 16'h2000,
   parameter logic [7:0]  RESET_MONTH = 8'h01,
   parameter logic [7:0]  RESET_DAY   = 8'h01
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic        day_tick,
   input  logic        load,
   input  logic [7:0]  load_day,
   input  logic [7:0]  load_month,
   input  logic [15:0] load_year,
   output logic [7:0]  day,
   output logic [7:0]  month,
   output logic [15:0] year,
   output logic        leap,
   output logic        month_tick,
   output logic        year_tick,
   output logic        load_err
);

   logic [7:0]  day_q, day_d;
   logic [7:0]  month_q, month_d;
   logic [15:0] year_q, year_d;
   logic        month_tick_q, month_tick_d;
   logic        year_tick_q, year_tick_d;
   logic        load_err_q, load_err_d;
   logic [7:0]  last_cur;
   logic [7:0]  last_load;
   logic        load_ok;

   // Divisibility by 4 of a two-digit BCD value, decided on the digits alone.
   function automatic logic pair_div4(input logic [7:0] p);
      logic [3:0] o;
      o = p[3:0];
      if (p[4]) return (o == 4'd2) || (o == 4'd6);
      else      return (o == 4'd0) || (o == 4'd4) || (o == 4'd8);
   endfunction

   function automatic logic is_leap(input logic [15:0] y);
      if (y[7:0] == 8'h00) return pair_div4(y[15:8]);
      else                 return pair_div4(y[7:0]);
   endfunction

   function automatic logic [7:0] last_day(input logic [7:0] m, input logic lp);
      logic [7:0] r;
      case (m)
         8'h02:                      r = lp ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
         default:                    r = 8'h31;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] inc_pair(input logic [7:0] p);
      if (p[3:0] == 4'd9) return {p[7:4] + 4'd1, 4'd0};
      else                return {p[7:4], p[3:0] + 4'd1};
   endfunction

   function automatic logic [15:0] inc_year(input logic [15:0] y);
      logic [15:0] r;
      logic        c;
      r = y;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic digits_ok(input logic [15:0] v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
   endfunction

   // Once every nibble is a decimal digit, plain binary compares order BCD values correctly.
   assign last_cur  = last_day(month_q, is_leap(year_q));
   assign last_load = last_day(load_month, is_leap(load_year));
   assign load_ok   = digits_ok(load_year) && digits_ok({load_month, load_day})
                      && (load_month != 8'h00) && (load_month <= 8'h12)
                      && (load_day != 8'h00) && (load_day <= last_load);

   always_comb begin
      day_d        = day_q;
      month_d      = month_q;
      year_d       = year_q;
      month_tick_d = 1'b0;
      year_tick_d  = 1'b0;
      load_err_d   = 1'b0;
      if (load) begin
         if (load_ok) begin
            day_d   = load_day;
            month_d = load_month;
            year_d  = load_year;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (day_tick) begin
         if (day_q != last_cur) begin
            day_d = inc_pair(day_q);
         end else begin
            day_d        = 8'h01;
            month_tick_d = 1'b1;
            if (month_q != 8'h12) begin
               month_d = inc_pair(month_q);
            end else begin
               month_d     = 8'h01;
               year_d      = inc_year(year_q);
               year_tick_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
         day_q        <= RESET_DAY;
         month_q      <= RESET_MONTH;
         year_q       <= RESET_YEAR;
         month_tick_q <= 1'b0;
         year_tick_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         day_q        <= day_d;
         month_q      <= month_d;
         year_q       <= year_d;
         month_tick_q <= month_tick_d;
         year_tick_q  <= year_tick_d;
         load_err_q   <= load_err_d;
      end
   end

   assign day        = day_q;
   assign month      = month_q;
   assign year       = year_q;
   assign leap       = is_leap(year_q);
   assign month_tick = month_tick_q;
   assign year_tick  = year_tick_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_date_bcd_counter.sv
// Scoreboard bench for date_bcd_counter: an integer calendar model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_date_bcd_counter;

   logic        clock_in = 1'b0;
   logic        reset = 1'b0;
   logic        day_tick = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  load_day = 8'h00;
   logic [7:0]  load_month = 8'h00;
   logic [15:0] load_year = 16'h0000;
   logic [7:0]  day;
   logic [7:0]  month;
   logic [15:0] year;
   logic        leap;
   logic        month_tick;
   logic        year_tick;
   logic        load_err;

   date_bcd_counter #(
      .RESET_YEAR (16'h2000),
      .RESET_MONTH(8'h01),
      .RESET_DAY  (8'h01)
   ) dut (
      .clock_in  (clock_in),
      .reset     (reset),
      .day_tick  (day_tick),
      .load      (load),
      .load_day  (load_day),
      .load_month(load_month),
      .load_year (load_year),
      .day       (day),
      .month     (month),
      .year      (year),
      .leap      (leap),
      .month_tick(month_tick),
      .year_tick (year_tick),
      .load_err  (load_err)
   );

   always #5 clock_in = ~clock_in;

   typedef struct {
      int          cyc;
      logic [7:0]  d;
      logic [7:0]  m;
      logic [15:0] y;
      logic        l;
      logic        mt;
      logic        yt;
      logic        le;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   md, mm, my;

   always @(posedge clock_in) cyc <= cyc + 1;

   function automatic bit leap_int(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   function automatic int dim(input int m, input int y);
      if (m == 2) return leap_int(y) ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   function automatic bit nib_ok(input logic [15:0] v);
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 0;
      return 1;
   endfunction

   function automatic int bcd2int(input logic [15:0] v);
      return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
   endfunction

   function automatic logic [15:0] to_bcd16(input int v);
      logic [15:0] r;
      r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      return r;
   endfunction

   function automatic logic [7:0] to_bcd8(input int v);
      logic [7:0] r;
      r = {4'((v / 10) % 10), 4'(v % 10)};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drive one edge's worth of inputs and predict the outputs that follow that edge.
   task automatic do_cycle(input bit tick, input bit ld, input logic [7:0] ld_d,
                           input logic [7:0] ld_m, input logic [15:0] ld_y);
      exp_t e;
      bit   ok;
      @(posedge clock_in);
      #2;
      day_tick   = tick;
      load       = ld;
      load_day   = ld_d;
      load_month = ld_m;
      load_year  = ld_y;
      e.mt = 0;
      e.yt = 0;
      e.le = 0;
      if (ld) begin
         ok = nib_ok({8'h00, ld_d}) && nib_ok({8'h00, ld_m}) && nib_ok(ld_y);
         if (ok) begin
            ok = bcd2int({8'h00, ld_m}) >= 1 && bcd2int({8'h00, ld_m}) <= 12
                 && bcd2int({8'h00, ld_d}) >= 1
                 && bcd2int({8'h00, ld_d}) <= dim(bcd2int({8'h00, ld_m}), bcd2int(ld_y));
         end
         if (ok) begin
            md = bcd2int({8'h00, ld_d});
            mm = bcd2int({8'h00, ld_m});
            my = bcd2int(ld_y);
         end else begin
            e.le = 1;
         end
      end else if (tick) begin
         if (md < dim(mm, my)) begin
            md++;
         end else begin
            md = 1;
            e.mt = 1;
            if (mm < 12) begin
               mm++;
            end else begin
               mm = 1;
               my = (my + 1) % 10000;
               e.yt = 1;
            end
         end
      end
      e.cyc = cyc + 1;
      e.d   = to_bcd8(md);
      e.m   = to_bcd8(mm);
      e.y   = to_bcd16(my);
      e.l   = leap_int(my);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) do_cycle(0, 0, 8'h00, 8'h00, 16'h0000);
   endtask

   task automatic ld(input logic [15:0] y, input logic [7:0] m, input logic [7:0] d);
      do_cycle(0, 1, d, m, y);
   endtask

   task automatic drain();
      idle(2);
      for (int i = 0; i < 6 && sb.size() > 0; i++) @(posedge clock_in);
      @(negedge clock_in);
      #1;
      check("scoreboard_drain", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_date"}, {day, month, year}, 32'h0101_2000);
      check({tag, "_flags"}, {28'h0, leap, month_tick, year_tick, load_err}, 32'h8);
   endtask

   // Monitor: every cycle with a pending prediction is compared in the low clock phase.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock_in);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            if (e.cyc != cyc || day !== e.d || month !== e.m || year !== e.y || leap !== e.l
                || month_tick !== e.mt || year_tick !== e.yt || load_err !== e.le) begin
               n_fail++;
               $display("FAIL cycle %0d: got %h-%h-%h l%b mt%b yt%b le%b, expected %h-%h-%h l%b mt%b yt%b le%b",
                        cyc, year, month, day, leap, month_tick, year_tick, load_err,
                        e.y, e.m, e.d, e.l, e.mt, e.yt, e.le);
            end
         end
      end
   end

   initial begin
      logic [15:0] years [8] = '{16'h1900, 16'h2000, 16'h2023, 16'h2024, 16'h2100,
                                 16'h9999, 16'h1996, 16'h2400};
      logic [15:0] ry;
      logic [7:0]  rm, rd;
      int          r, mi, yi;

      md = 1; mm = 1; my = 2000;
      repeat (3) @(posedge clock_in);
      #1;
      check_reset_vals("in_reset");
      @(posedge clock_in);
      #2;
      reset = 1'b1;

      repeat (31) do_cycle(1, 0, 8'h00, 8'h00, 16'h0000);
      idle(2);

      ld(16'h2000, 8'h02, 8'h28); repeat (2) do_cycle(1, 0, 8'h00, 8'h00, 16'h0000);
      ld(16'h1900, 8'h02, 8'h28); do_cycle(1, 0, 8'h00, 8'h00, 16'h0000);
      ld(16'h2024, 8'h02, 8'h28); do_cycle(1, 0, 8'h00, 8'h00, 16'h0000);
      ld(16'h9999, 8'h12, 8'h31); do_cycle(1, 0, 8'h00, 8'h00, 16'h0000);
      idle(1);

      ld(16'h2023, 8'h02, 8'h29); idle(1);
      ld(16'h2023, 8'h13, 8'h01); idle(1);
      ld(16'h2023, 8'h01, 8'h0A); idle(1);
      ld(16'h2023, 8'h01, 8'h00); idle(1);
      ld(16'h2023, 8'h00, 8'h10); idle(1);

      do_cycle(1, 1, 8'h15, 8'h06, 16'h2010); idle(2);

      for (int i = 0; i < 2500; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            yi = $urandom_range(0, 8);
            ry = (yi == 8) ? to_bcd16($urandom_range(0, 9999)) : years[yi];
            mi = $urandom_range(0, 13);
            rm = to_bcd8(mi);
            if ($urandom_range(0, 1) == 1)
               rd = to_bcd8(dim((mi < 1 || mi > 12) ? 1 : mi, bcd2int(ry))
                            - 1 + $urandom_range(0, 2));
            else
               rd = to_bcd8($urandom_range(0, 32));
            if ($urandom_range(0, 19) == 0) rd = 8'($urandom);
            if ($urandom_range(0, 19) == 0) rm = 8'($urandom);
            do_cycle(r < 2, 1, rd, rm, ry);
         end else begin
            do_cycle(r < 75, 0, 8'h00, 8'h00, 16'h0000);
         end
      end
      drain();

      // Async reset while a month_tick pulse is being presented.
      ld(16'h2000, 8'h01, 8'h31);
      drain();
      @(posedge clock_in);
      #2;
      day_tick = 1'b1;
      @(posedge clock_in);
      #1;
      day_tick = 1'b0;
      check("pulse_before_reset", {day, month, 15'h0, month_tick}, {8'h01, 8'h02, 16'h0001});
      #2;
      reset = 1'b0;
      #1;
      check_reset_vals("async_reset");
      @(posedge clock_in);
      #1;
      check_reset_vals("held_reset");
      #1;
      reset = 1'b1;
      md = 1; mm = 1; my = 2000;
      repeat (3) do_cycle(1, 0, 8'h00, 8'h00, 16'h0000);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
